// File: rtl/xgmii_rate_pkg.sv
// Shared constants for the XGMII receive-rate monitor: default counter widths,
// the 1 s window at 156.25 MHz and the layout of the per-channel length word.
package xgmii_rate_pkg;

  localparam int DEF_BYTE_W      = 32;
  localparam int DEF_PKT_W       = 28;
  localparam int DEF_TICK_CYCLES = 156250000;

  localparam int LEN_ERR_BIT = 15;
  localparam int LEN_W       = 15;

endpackage

// File: rtl/xgmii_rate_ch.sv
// One receive channel: classifies eop events, keeps saturating per-window
// accumulators, snapshots them on the shared terminal cycle and holds peaks.
module xgmii_rate_ch
  import xgmii_rate_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int PKT_W  = DEF_PKT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              term,
  input  logic              clr_peak,
  input  logic              weop,
  input  logic [15:0]       wlen,
  output logic [BYTE_W-1:0] byte_rate,
  output logic [PKT_W-1:0]  pps_rate,
  output logic [PKT_W-1:0]  err_rate,
  output logic [BYTE_W-1:0] peak_byte,
  output logic [PKT_W-1:0]  peak_pps,
  output logic [1:0]        stat_inc
);

  // One spare bit above the wider of accumulator and length detects overflow.
  localparam int SW = ((BYTE_W > LEN_W) ? BYTE_W : LEN_W) + 1;

  logic              good;
  logic              bad;
  logic [SW-1:0]     byte_sum;
  logic [BYTE_W-1:0] byte_acc;
  logic [BYTE_W-1:0] byte_nxt;
  logic [PKT_W-1:0]  pkt_acc;
  logic [PKT_W-1:0]  pkt_nxt;
  logic [PKT_W-1:0]  err_acc;
  logic [PKT_W-1:0]  err_nxt;
  logic [BYTE_W-1:0] peak_byte_base;
  logic [PKT_W-1:0]  peak_pps_base;

  always_comb begin
    good     = weop & ~wlen[LEN_ERR_BIT];
    bad      = weop &  wlen[LEN_ERR_BIT];
    byte_sum = SW'(byte_acc) + (good ? SW'(wlen[LEN_W-1:0]) : '0);
    byte_nxt = (|byte_sum[SW-1:BYTE_W]) ? '1 : byte_sum[BYTE_W-1:0];
    pkt_nxt  = (good && !(&pkt_acc)) ? pkt_acc + PKT_W'(1) : pkt_acc;
    err_nxt  = (bad  && !(&err_acc)) ? err_acc + PKT_W'(1) : err_acc;
    // Clear first, so a coincident snapshot compares against zero.
    peak_byte_base = clr_peak ? '0 : peak_byte;
    peak_pps_base  = clr_peak ? '0 : peak_pps;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_acc  <= '0;
      pkt_acc   <= '0;
      err_acc   <= '0;
      byte_rate <= '0;
      pps_rate  <= '0;
      err_rate  <= '0;
      peak_byte <= '0;
      peak_pps  <= '0;
      stat_inc  <= '0;
    end else begin
      stat_inc <= {bad, good};
      if (term) begin
        byte_acc  <= '0;
        pkt_acc   <= '0;
        err_acc   <= '0;
        byte_rate <= byte_nxt;
        pps_rate  <= pkt_nxt;
        err_rate  <= err_nxt;
        peak_byte <= (byte_nxt > peak_byte_base) ? byte_nxt : peak_byte_base;
        peak_pps  <= (pkt_nxt > peak_pps_base) ? pkt_nxt : peak_pps_base;
      end else begin
        byte_acc  <= byte_nxt;
        pkt_acc   <= pkt_nxt;
        err_acc   <= err_nxt;
        peak_byte <= peak_byte_base;
        peak_pps  <= peak_pps_base;
      end
    end
  end

endmodule

// File: rtl/xgmii_nch_rx_rate_mon.sv
// N-channel XGMII receive-rate monitor: owns the measurement window counter
// and tick, and instantiates one rate channel per receive port.
module xgmii_nch_rx_rate_mon
  import xgmii_rate_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int BYTE_W      = DEF_BYTE_W,
  parameter int PKT_W       = DEF_PKT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_peak,
  input  logic [NUM_CH-1:0]        ch_weop,
  input  logic [NUM_CH*16-1:0]     ch_wlen,
  output logic                     tick,
  output logic [NUM_CH*BYTE_W-1:0] byte_rate,
  output logic [NUM_CH*PKT_W-1:0]  pps_rate,
  output logic [NUM_CH*PKT_W-1:0]  err_rate,
  output logic [NUM_CH*BYTE_W-1:0] peak_byte,
  output logic [NUM_CH*PKT_W-1:0]  peak_pps,
  output logic [NUM_CH*2-1:0]      stat_inc
);

  localparam int            CW   = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          term;

  assign term = (cnt == LAST);

  // Wrapping at LAST keeps tick spacing exactly TICK_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= term;
      cnt  <= term ? '0 : cnt + CW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    xgmii_rate_ch #(
      .BYTE_W (BYTE_W),
      .PKT_W  (PKT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .term      (term),
      .clr_peak  (clr_peak),
      .weop      (ch_weop[i]),
      .wlen      (ch_wlen[16*i +: 16]),
      .byte_rate (byte_rate[BYTE_W*i +: BYTE_W]),
      .pps_rate  (pps_rate[PKT_W*i +: PKT_W]),
      .err_rate  (err_rate[PKT_W*i +: PKT_W]),
      .peak_byte (peak_byte[BYTE_W*i +: BYTE_W]),
      .peak_pps  (peak_pps[PKT_W*i +: PKT_W]),
      .stat_inc  (stat_inc[2*i +: 2])
    );
  end

endmodule
